// File: rtl/ntt_sched_pkg.sv
// Shared types and helpers for the NTT stage scheduler.
//   sched_state_e : scheduler FSM states
//   bf_addr_t     : {a, b, tw} address triple of one butterfly
//   bf_addr()     : read/twiddle addresses of butterfly k in stage s
`timescale 1ns/1ps

`ifndef INTMUL_DELAY
`define INTMUL_DELAY 3
`endif
`ifndef MODRED_DELAY
`define MODRED_DELAY 2
`endif

package ntt_sched_pkg;

  // Default configuration: transform length, butterfly and RAM latencies.
  localparam int unsigned DEF_RING_SIZE  = 256;
  localparam int unsigned DEF_BF_LATENCY = `INTMUL_DELAY + `MODRED_DELAY;
  localparam int unsigned DEF_RD_LATENCY = 1;
  localparam int unsigned L = $clog2(DEF_RING_SIZE);
  localparam int unsigned D = DEF_RD_LATENCY + DEF_BF_LATENCY;

  // Address fields sized for the largest supported transform.
  localparam int unsigned BF_ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [BF_ADDR_W-1:0] a;
    logic [BF_ADDR_W-1:0] b;
    logic [BF_ADDR_W-1:0] tw;
  } bf_addr_t;

  // Even/odd leg addresses and twiddle index for butterfly k of stage s
  // in an L-level (l) in-place DIT transform.
  function automatic bf_addr_t bf_addr(input int unsigned l,
                                       input int unsigned s,
                                       input int unsigned k);
    int unsigned len;
    int unsigned grp;
    int unsigned pos;
    int unsigned a;
    bf_addr_t    r;
    len  = 32'd1 << s;
    grp  = k >> s;
    pos  = k & (len - 32'd1);
    a    = (grp << (s + 32'd1)) | pos;
    r.a  = BF_ADDR_W'(a);
    r.b  = BF_ADDR_W'(a + len);
    r.tw = BF_ADDR_W'(pos << (l - 32'd1 - s));
    return r;
  endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// Write-back delay line: shifts {valid, addr_a, addr_b} by DEPTH cycles so
// the write strobe lines up with the butterfly result.
//   clk, reset           : clock, synchronous active-high clear
//   i_valid, i_addr_a/b  : issue strobe and read addresses
//   o_valid, o_addr_a/b  : same, DEPTH cycles later
`timescale 1ns/1ps

module ntt_wb_delay #(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [ADDR_W-1:0] i_addr_b,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr_a,
  output logic [ADDR_W-1:0] o_addr_b
);

  localparam int unsigned EW = 2 * ADDR_W + 1;

  logic [EW-1:0]            w_in;
  logic [DEPTH-1:0][EW-1:0] r_pipe;

  assign w_in = {i_valid, i_addr_a, i_addr_b};

  // Entry 0 is the newest; the oldest entry drives the outputs.
  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (reset) r_pipe <= '0;
      else       r_pipe <= w_in;
    end
  end else begin : g_many
    always_ff @(posedge clk) begin
      if (reset) r_pipe <= '0;
      else       r_pipe <= {r_pipe[DEPTH-2:0], w_in};
    end
  end

  assign {o_valid, o_addr_a, o_addr_b} = r_pipe[DEPTH-1];

endmodule

// File: rtl/ntt_stage_scheduler.sv
// Issue sequencer for an in-place radix-2 DIT NTT (bit-reversed input).
// One butterfly per cycle in RUN, a drain gap of RD_LATENCY+BF_LATENCY
// cycles after every stage so reads never overtake pending write-backs.
//   clk, reset          : clock, synchronous active-high reset
//   start               : transform request, honoured only when idle
//   busy, done          : activity flag, one-cycle completion pulse
//   rd_en, rd_addr_a/b  : butterfly issue strobe and operand addresses
//   tw_addr, stage      : twiddle ROM index and stage of the current issue
//   wr_en, wr_addr_a/b  : write-back strobe/addresses aligned to results
`timescale 1ns/1ps

`ifndef INTMUL_DELAY
`define INTMUL_DELAY 3
`endif
`ifndef MODRED_DELAY
`define MODRED_DELAY 2
`endif

module ntt_stage_scheduler
  import ntt_sched_pkg::*;
#(
  parameter int unsigned RING_SIZE  = 256,
  parameter int unsigned BF_LATENCY = `INTMUL_DELAY + `MODRED_DELAY,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  rd_en,
  output logic [$clog2(RING_SIZE)-1:0]          rd_addr_a,
  output logic [$clog2(RING_SIZE)-1:0]          rd_addr_b,
  output logic [$clog2(RING_SIZE)-2:0]          tw_addr,
  output logic [$clog2($clog2(RING_SIZE))-1:0]  stage,
  output logic                                  wr_en,
  output logic [$clog2(RING_SIZE)-1:0]          wr_addr_a,
  output logic [$clog2(RING_SIZE)-1:0]          wr_addr_b
);

  localparam int unsigned ADDR_W = $clog2(RING_SIZE);
  localparam int unsigned KW     = ADDR_W - 1;
  localparam int unsigned SW     = $clog2(ADDR_W);
  localparam int unsigned DEPTH  = RD_LATENCY + BF_LATENCY;
  localparam int unsigned DW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(RING_SIZE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(ADDR_W - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEPTH - 1);

  sched_state_e      r_state, w_state;
  logic [KW-1:0]     r_k, w_k;
  logic [SW-1:0]     r_s, w_s;
  logic [DW-1:0]     r_d, w_d;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_rd_en, w_rd_en;
  logic [ADDR_W-1:0] r_rd_a, r_rd_b;
  logic [ADDR_W-2:0] r_tw;
  bf_addr_t          w_bf;
  logic              w_unused_bf;

  // Next state, counters and issue decision; k/s here name the butterfly
  // that will be on the read port in the following cycle.
  always_comb begin
    w_state = r_state;
    w_k     = r_k;
    w_s     = r_s;
    w_d     = r_d;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_rd_en = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state = ST_RUN;
          w_k     = '0;
          w_s     = '0;
          w_busy  = 1'b1;
          w_rd_en = 1'b1;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (r_k == K_LAST) begin
          w_state = ST_DRAIN;
          w_k     = '0;
          w_d     = '0;
        end else begin
          w_k     = r_k + 1'b1;
          w_rd_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_d == D_LAST) begin
          if (r_s == S_LAST) begin
            w_state = ST_DONE;
            w_done  = 1'b1;
          end else begin
            w_state = ST_RUN;
            w_s     = r_s + 1'b1;
            w_busy  = 1'b1;
            w_rd_en = 1'b1;
          end
        end else begin
          w_d    = r_d + 1'b1;
          w_busy = 1'b1;
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
        w_s     = '0;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign w_bf        = bf_addr(ADDR_W, 32'(w_s), 32'(w_k));
  assign w_unused_bf = ^w_bf;

  // State, counters and registered issue-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_s     <= '0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_tw    <= '0;
    end else begin
      r_state <= w_state;
      r_k     <= w_k;
      r_s     <= w_s;
      r_d     <= w_d;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_rd_en <= w_rd_en;
      if (w_rd_en) begin
        r_rd_a <= ADDR_W'(w_bf.a);
        r_rd_b <= ADDR_W'(w_bf.b);
        r_tw   <= (ADDR_W - 1)'(w_bf.tw);
      end
    end
  end

  // Write-back strobes trail the issue by the full read+butterfly latency.
  ntt_wb_delay #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_wb_delay (
    .clk      (clk),
    .reset    (reset),
    .i_valid  (r_rd_en),
    .i_addr_a (r_rd_a),
    .i_addr_b (r_rd_b),
    .o_valid  (wr_en),
    .o_addr_a (wr_addr_a),
    .o_addr_b (wr_addr_b)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en     = r_rd_en;
  assign rd_addr_a = r_rd_a;
  assign rd_addr_b = r_rd_b;
  assign tw_addr   = r_tw;
  assign stage     = r_s;

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Scoreboard bench for ntt_stage_scheduler: a small (N=8, D=3) and a full
// size (N=256, D=6) instance run directed and random start/reset traffic.
`timescale 1ns/1ps

module tb_ntt_stage_scheduler;

  typedef struct packed {
    int unsigned cyc;
    int unsigned a;
    int unsigned b;
    int unsigned tw;
    int unsigned st;
  } ev_t;

  logic        clk = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          fin [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int unsigned N  = (g == 0) ? 8 : 256;
    localparam int unsigned BF = (g == 0) ? 2 : 5;
    localparam int unsigned RD = 1;
    localparam int unsigned L  = $clog2(N);
    localparam int unsigned H  = N / 2;
    localparam int unsigned D  = RD + BF;
    localparam int unsigned T  = L * (H + D) + 2;

    logic                 start_r = 1'b0;
    logic                 reset_r = 1'b1;
    logic                 busy, done, rd_en, wr_en;
    logic [L-1:0]         rd_a, rd_b, wr_a, wr_b;
    logic [L-2:0]         tw;
    logic [$clog2(L)-1:0] stage;

    ev_t         rd_q[$];
    ev_t         wr_q[$];
    int unsigned done_q[$];
    int unsigned pend [N];
    int unsigned busy_from = 1, busy_to = 0, free_at = 0, zero_at = 0;
    int unsigned rd_seen = 0, wr_seen = 0;
    bit          mon_en = 1'b0;

    ntt_stage_scheduler #(
      .RING_SIZE  (N),
      .BF_LATENCY (BF),
      .RD_LATENCY (RD)
    ) u_dut (
      .clk       (clk),
      .reset     (reset_r),
      .start     (start_r),
      .busy      (busy),
      .done      (done),
      .rd_en     (rd_en),
      .rd_addr_a (rd_a),
      .rd_addr_b (rd_b),
      .tw_addr   (tw),
      .stage     (stage),
      .wr_en     (wr_en),
      .wr_addr_a (wr_a),
      .wr_addr_b (wr_b)
    );

    // Reference: stage s visits groups of 2*len coefficients, pairing j with
    // j+len; the twiddle step is N/(2*len). Issue slots are back to back,
    // stages are N/2+D cycles apart, write-backs trail reads by D.
    task automatic push_transform(input int unsigned t0);
      ev_t         ev;
      int unsigned len;
      int unsigned c;
      for (int unsigned s = 0; s < L; s++) begin
        len = 32'd1 << s;
        c   = t0 + 1 + s * (H + D);
        for (int unsigned base = 0; base < N; base += 2 * len) begin
          for (int unsigned j = 0; j < len; j++) begin
            ev.cyc = c;
            ev.a   = base + j;
            ev.b   = base + j + len;
            ev.tw  = j * (N / (2 * len));
            ev.st  = s;
            rd_q.push_back(ev);
            ev.cyc = c + D;
            wr_q.push_back(ev);
            c++;
          end
        end
      end
      done_q.push_back(t0 + T - 1);
    endtask

    // One cycle of stimulus, with the model updated for what the DUT will see.
    task automatic drive(input logic st, input logic rs);
      @(negedge clk);
      #1;
      start_r = st;
      reset_r = rs;
      if (rs) begin
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        foreach (pend[i]) pend[i] = 0;
        zero_at = cyc + 1;
        busy_to = cyc;
        free_at = cyc + 1;
        mon_en  = 1'b1;
      end else if (st && cyc >= free_at) begin
        push_transform(cyc);
        busy_from = cyc + 1;
        busy_to   = cyc + T - 2;
        free_at   = cyc + T;
      end
    endtask

    // Monitor: compares every visible output against the scoreboard queues.
    always @(negedge clk) begin
      bit exp_rd, exp_wr, exp_done, exp_busy;
      if (mon_en) begin
        if (cyc == zero_at)
          chk($sformatf("N%0d_reset_outputs", N),
              64'({busy, done, rd_en, wr_en, rd_a, rd_b, tw, stage, wr_a, wr_b}), 64'd0);

        exp_rd = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
        chk($sformatf("N%0d_rd_en", N), 64'(rd_en), 64'(exp_rd));
        if (exp_rd && rd_en === 1'b1) begin
          chk($sformatf("N%0d_rd_addr_a", N), 64'(rd_a),  64'(rd_q[0].a));
          chk($sformatf("N%0d_rd_addr_b", N), 64'(rd_b),  64'(rd_q[0].b));
          chk($sformatf("N%0d_tw_addr", N),   64'(tw),    64'(rd_q[0].tw));
          chk($sformatf("N%0d_stage", N),     64'(stage), 64'(rd_q[0].st));
        end
        if (exp_rd) void'(rd_q.pop_front());
        if (rd_en === 1'b1) begin
          rd_seen++;
          chk($sformatf("N%0d_hazard_a", N), 64'(pend[rd_a]), 64'd0);
          chk($sformatf("N%0d_hazard_b", N), 64'(pend[rd_b]), 64'd0);
          pend[rd_a]++;
          pend[rd_b]++;
        end

        exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
        chk($sformatf("N%0d_wr_en", N), 64'(wr_en), 64'(exp_wr));
        if (exp_wr && wr_en === 1'b1) begin
          chk($sformatf("N%0d_wr_addr_a", N), 64'(wr_a), 64'(wr_q[0].a));
          chk($sformatf("N%0d_wr_addr_b", N), 64'(wr_b), 64'(wr_q[0].b));
        end
        if (exp_wr) void'(wr_q.pop_front());
        if (wr_en === 1'b1) begin
          wr_seen++;
          if (pend[wr_a] > 0) pend[wr_a]--;
          if (pend[wr_b] > 0) pend[wr_b]--;
        end

        exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
        chk($sformatf("N%0d_done", N), 64'(done), 64'(exp_done));
        if (exp_done) void'(done_q.pop_front());

        exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
        chk($sformatf("N%0d_busy", N), 64'(busy), 64'(exp_busy));
      end
    end

    initial begin
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
      repeat (3) drive(1'b0, 1'b0);

      // Single start pulse, full transform.
      drive(1'b1, 1'b0);
      repeat (T + 5) drive(1'b0, 1'b0);
      chk($sformatf("N%0d_rd_count", N), 64'(rd_seen), 64'(L * H));
      chk($sformatf("N%0d_wr_count", N), 64'(wr_seen), 64'(L * H));

      // start held high: second request accepted only once back in IDLE.
      repeat (T + 7) drive(1'b1, 1'b0);
      repeat (T + 5) drive(1'b0, 1'b0);

      // Reset ten cycles into a run.
      drive(1'b1, 1'b0);
      repeat (9) drive(1'b0, 1'b0);
      drive(1'b0, 1'b1);
      repeat (2 * T) drive(1'b0, 1'b0);

      // Random start/reset traffic.
      for (int unsigned i = 0; i < 4 * T; i++)
        drive(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 16 * T) == 0));
      repeat (T + 5) drive(1'b0, 1'b0);

      chk($sformatf("N%0d_rd_left", N),   64'(rd_q.size()),   64'd0);
      chk($sformatf("N%0d_wr_left", N),   64'(wr_q.size()),   64'd0);
      chk($sformatf("N%0d_done_left", N), 64'(done_q.size()), 64'd0);
      fin[g] = 1'b1;
    end
  end

  initial begin
    wait (fin[0] && fin[1]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: run did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
